// File: rtl/hdmi_tx_phy_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_tx_phy_seq
//  Description : Bring-up / shut-down sequencer for the HDMI TX serializer PHY
//                in the pixel-clock domain. Holds the PHY in reset until PLL
//                lock, software enable and debounced hot-plug are all present.
//                It then releases the PHY and sends control tokens for a settle
//                window before it passes encoded video through. On unplug or
//                disable it drains with tokens before reasserting PHY reset.
//  Ports       : I_pixel_clk / I_rst          clock, async active-high reset
//                I_pll_locked, I_hpd           async inputs, synchronized here
//                I_enable                      synchronous software enable
//                I_tmds_channel_0..2           encoded video words in
//                O_phy_rst                     PHY wrapper reset (active-high)
//                O_tmds_channel_0..2, _clk     registered lane words to PHY
//                O_video_active, O_state       status
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_tx_phy_seq #(
    parameter int         LOCK_DLY  = 1024,
    parameter int         IDLE_CYC  = 64,
    parameter int         DRAIN_CYC = 16,
    parameter int         HPD_DEB   = 4096,
    parameter logic [9:0] CTL_TOKEN = 10'b1101010100,
    parameter logic [9:0] CLK_WORD  = 10'b1111100000
) (
    input  logic       I_pixel_clk,
    input  logic       I_rst,
    input  logic       I_pll_locked,
    input  logic       I_hpd,
    input  logic       I_enable,
    input  logic [9:0] I_tmds_channel_0,
    input  logic [9:0] I_tmds_channel_1,
    input  logic [9:0] I_tmds_channel_2,
    output logic       O_phy_rst,
    output logic [9:0] O_tmds_channel_0,
    output logic [9:0] O_tmds_channel_1,
    output logic [9:0] O_tmds_channel_2,
    output logic [9:0] O_tmds_channel_clk,
    output logic       O_video_active,
    output logic [2:0] O_state
);

    localparam int CNT_MAX_A = (LOCK_DLY > IDLE_CYC) ? LOCK_DLY : IDLE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > DRAIN_CYC) ? CNT_MAX_A : DRAIN_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;
    localparam int DEB_W     = $clog2(HPD_DEB) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_DLY - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(HPD_DEB - 1);

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOCK  = 3'd1,
        IDLE  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;

    // ------------------------------------------------------------------
    // Input synchronizers and HPD debounce
    // ------------------------------------------------------------------
    logic             lock_s1, lock_sync;
    logic             hpd_s1, hpd_sync;
    logic             hpd_filt;
    logic [DEB_W-1:0] deb_cnt;
    logic             go;

    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
            hpd_s1    <= 1'b0;
            hpd_sync  <= 1'b0;
        end else begin
            lock_s1   <= I_pll_locked;
            lock_sync <= lock_s1;
            hpd_s1    <= I_hpd;
            hpd_sync  <= hpd_s1;
        end
    end

    // The filtered value flips on the HPD_DEB-th consecutive cycle in which
    // the synchronized value disagrees with it; any agreement restarts the run.
    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            hpd_filt <= 1'b0;
            deb_cnt  <= '0;
        end else if (hpd_sync == hpd_filt) begin
            deb_cnt  <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            hpd_filt <= hpd_sync;
            deb_cnt  <= '0;
        end else begin
            deb_cnt  <= deb_cnt + 1'b1;
        end
    end

    assign go = lock_sync & hpd_filt & I_enable;

    // ------------------------------------------------------------------
    // State register and shared counter
    // ------------------------------------------------------------------
    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= HOLD;
            cnt   <= '0;
        end else begin
            state <= next_state;
            // Counter restarts on every state entry and only runs in the
            // timed states, so it never wraps while idle in HOLD or RUN.
            if (next_state != state)
                cnt <= '0;
            else if (state == LOCK || state == IDLE || state == DRAIN)
                cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next-cycle output values. Outputs are decoded from
    // next_state so that they change on the same edge as O_state.
    // ------------------------------------------------------------------
    logic       phy_rst_d;
    logic [9:0] lane0_d, lane1_d, lane2_d, lane_clk_d;
    logic       video_d;

    always_comb begin
        next_state = state;
        case (state)
            HOLD:  if (go) next_state = LOCK;
            LOCK: begin
                if (!go)                     next_state = HOLD;
                else if (cnt == LOCK_LAST)   next_state = IDLE;
            end
            IDLE: begin
                if (!lock_sync)                      next_state = HOLD;
                else if (!hpd_filt || !I_enable)     next_state = DRAIN;
                else if (cnt == IDLE_LAST)           next_state = RUN;
            end
            RUN: begin
                if (!lock_sync)                      next_state = HOLD;
                else if (!hpd_filt || !I_enable)     next_state = DRAIN;
            end
            // Only lock loss may cut a drain short; re-qualified go cannot.
            DRAIN: begin
                if (!lock_sync)                      next_state = HOLD;
                else if (cnt == DRAIN_LAST)          next_state = HOLD;
            end
            default: next_state = HOLD;
        endcase

        phy_rst_d  = 1'b1;
        lane0_d    = 10'd0;
        lane1_d    = 10'd0;
        lane2_d    = 10'd0;
        lane_clk_d = 10'd0;
        video_d    = 1'b0;
        case (next_state)
            IDLE, DRAIN: begin
                phy_rst_d  = 1'b0;
                lane0_d    = CTL_TOKEN;
                lane1_d    = CTL_TOKEN;
                lane2_d    = CTL_TOKEN;
                lane_clk_d = CLK_WORD;
            end
            RUN: begin
                phy_rst_d  = 1'b0;
                lane0_d    = I_tmds_channel_0;
                lane1_d    = I_tmds_channel_1;
                lane2_d    = I_tmds_channel_2;
                lane_clk_d = CLK_WORD;
                video_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            O_phy_rst          <= 1'b1;
            O_tmds_channel_0   <= 10'd0;
            O_tmds_channel_1   <= 10'd0;
            O_tmds_channel_2   <= 10'd0;
            O_tmds_channel_clk <= 10'd0;
            O_video_active     <= 1'b0;
        end else begin
            O_phy_rst          <= phy_rst_d;
            O_tmds_channel_0   <= lane0_d;
            O_tmds_channel_1   <= lane1_d;
            O_tmds_channel_2   <= lane2_d;
            O_tmds_channel_clk <= lane_clk_d;
            O_video_active     <= video_d;
        end
    end

    assign O_state = state;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_tx_phy_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_tx_phy_seq
//  Description : Self-checking bench for hdmi_tx_phy_seq (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_tx_phy_seq;

    localparam int         LOCK_DLY  = 1024;
    localparam int         IDLE_CYC  = 64;
    localparam int         DRAIN_CYC = 16;
    localparam int         HPD_DEB   = 4096;
    localparam logic [9:0] TOKEN     = 10'h354;
    localparam logic [9:0] CLKW      = 10'h3E0;

    logic       clk, rst, lock, hpd, en;
    logic [9:0] ch0, ch1, ch2;
    logic       phy_rst, video;
    logic [9:0] o0, o1, o2, oclk;
    logic [2:0] st;

    hdmi_tx_phy_seq dut (
        .I_pixel_clk        (clk),
        .I_rst              (rst),
        .I_pll_locked       (lock),
        .I_hpd              (hpd),
        .I_enable           (en),
        .I_tmds_channel_0   (ch0),
        .I_tmds_channel_1   (ch1),
        .I_tmds_channel_2   (ch2),
        .O_phy_rst          (phy_rst),
        .O_tmds_channel_0   (o0),
        .O_tmds_channel_1   (o1),
        .O_tmds_channel_2   (o2),
        .O_tmds_channel_clk (oclk),
        .O_video_active     (video),
        .O_state            (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] in0, in1, in2;
        logic [9:0] exp0, exp1, exp2;
        logic       exp_va;
    } vec_t;

    vec_t vecs [6];
    vec_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (st != s && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        int   bad;
        bit   seen;
        vec_t e;

        vecs[0] = '{10'h2AB, 10'h0F0, 10'h111, 10'h2AB, 10'h0F0, 10'h111, 1'b1};
        vecs[1] = '{10'h000, 10'h3FF, 10'h155, 10'h000, 10'h3FF, 10'h155, 1'b1};
        vecs[2] = '{10'h3FF, 10'h000, 10'h2AA, 10'h3FF, 10'h000, 10'h2AA, 1'b1};
        vecs[3] = '{10'h155, 10'h2AA, 10'h3FF, 10'h155, 10'h2AA, 10'h3FF, 1'b1};
        vecs[4] = '{10'h354, 10'h0AB, 10'h001, 10'h354, 10'h0AB, 10'h001, 1'b1};
        vecs[5] = '{10'h200, 10'h100, 10'h080, 10'h200, 10'h100, 10'h080, 1'b1};

        rst = 1'b1; lock = 1'b0; hpd = 1'b0; en = 1'b0;
        ch0 = '0; ch1 = '0; ch2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_phy_rst", phy_rst, 1);
        chk("reset_lane0", o0, 0);
        chk("reset_lane_clk", oclk, 0);
        chk("reset_video", video, 0);
        chk("reset_state", st, 0);

        // Bring-up: 2 sync + HPD_DEB debounce + HOLD->LOCK + LOCK_DLY
        rst = 1'b0; lock = 1'b1; hpd = 1'b1; en = 1'b1;
        wait_state(3'd2, 20000, n);
        chk("bringup_latency", n, HPD_DEB + LOCK_DLY + 3);
        chk("idle_phy_rst", phy_rst, 0);
        chk("idle_lane0", o0, TOKEN);
        chk("idle_lane1", o1, TOKEN);
        chk("idle_lane2", o2, TOKEN);
        chk("idle_lane_clk", oclk, CLKW);
        chk("idle_video", video, 0);

        wait_state(3'd3, 1000, n);
        chk("idle_length", n, IDLE_CYC);
        chk("run_video", video, 1);

        // Passthrough vectors through a scoreboard
        for (int i = 0; i < 6; i++) begin
            ch0 = vecs[i].in0; ch1 = vecs[i].in1; ch2 = vecs[i].in2;
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("run_lane0_v%0d", i), o0, e.exp0);
            chk($sformatf("run_lane1_v%0d", i), o1, e.exp1);
            chk($sformatf("run_lane2_v%0d", i), o2, e.exp2);
            chk($sformatf("run_video_v%0d", i), video, e.exp_va);
        end
        chk("run_lane_clk", oclk, CLKW);

        // HPD glitch one cycle short of the debounce window
        hpd = 1'b0;
        repeat (HPD_DEB - 1) tick();
        hpd = 1'b1;
        repeat (8) tick();
        chk("hpd_glitch_stays_run", st, 3);

        // Real unplug: drain with tokens, then HOLD
        hpd = 1'b0;
        wait_state(3'd4, 10000, n);
        chk("unplug_latency", n, HPD_DEB + 3);
        chk("drain_lane0_entry", o0, TOKEN);
        chk("drain_phy_rst", phy_rst, 0);
        n = 0; bad = 0;
        while (st == 3'd4 && n < 100) begin
            tick();
            n++;
            if (st == 3'd4 && (o0 != TOKEN || o1 != TOKEN || o2 != TOKEN || oclk != CLKW)) bad++;
        end
        chk("drain_length", n, DRAIN_CYC);
        chk("drain_token_errors", bad, 0);
        chk("after_drain_state", st, 0);
        chk("after_drain_phy_rst", phy_rst, 1);
        chk("after_drain_lane0", o0, 0);
        chk("after_drain_lane_clk", oclk, 0);

        // Re-qualify, then one-cycle enable drop: drain must run to completion
        hpd = 1'b1;
        wait_state(3'd3, 20000, n);
        chk("requal_run", st, 3);
        en = 1'b0;
        tick();
        chk("disable_to_drain", st, 4);
        en = 1'b1;
        n = 0;
        while (st == 3'd4 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_not_aborted_len", n, DRAIN_CYC);
        chk("drain_not_aborted_state", st, 0);
        tick();
        chk("hold_requalifies", st, 1);

        // Lock glitch around cycle 500 of LOCK restarts the full LOCK_DLY
        repeat (499) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        n = 1; seen = 1'b0;
        while (st != 3'd2 && n < 5000) begin
            tick();
            n++;
            if (st == 3'd0) seen = 1'b1;
        end
        chk("lock_glitch_saw_hold", seen, 1);
        chk("lock_glitch_to_idle", n, LOCK_DLY + 4);

        // Lock loss in RUN: straight to HOLD, no drain
        wait_state(3'd3, 1000, n);
        chk("run_before_lockloss", st, 3);
        lock = 1'b0;
        n = 0;
        while (st == 3'd3 && n < 100) begin
            tick();
            n++;
        end
        chk("lockloss_latency", n, 3);
        chk("lockloss_state", st, 0);
        chk("lockloss_phy_rst", phy_rst, 1);
        chk("lockloss_lane0", o0, 0);
        chk("lockloss_lane_clk", oclk, 0);
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (st == 3'd4) seen = 1'b1;
        end
        chk("lockloss_no_drain", seen, 0);

        // Async reset in the middle of a drain
        lock = 1'b1;
        wait_state(3'd3, 5000, n);
        en = 1'b0;
        tick();
        chk("pre_reset_drain", st, 4);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", st, 0);
        chk("async_rst_phy_rst", phy_rst, 1);
        chk("async_rst_lane0", o0, 0);
        chk("async_rst_lane2", o2, 0);
        chk("async_rst_lane_clk", oclk, 0);
        chk("async_rst_video", video, 0);
        repeat (2) tick();
        rst = 1'b0;
        en = 1'b1;
        repeat (10) tick();
        chk("post_reset_hold", st, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
